// File: rtl/channel_encoder8_3.sv
// Sequential 8-to-3 channel encoder: captures a request vector and streams the
// index of every set bit, lowest first, one per valid/ready handshake.
module channel_encoder8_3 (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enable,
    input  logic       Load,
    input  logic [7:0] Din,
    input  logic       Ready,
    output logic [2:0] Bout,
    output logic       Valid,
    output logic       Busy,
    output logic       Done,
    output logic       MultiHot,
    output logic [3:0] Count
);

    localparam logic IDLE = 1'b0;
    localparam logic EMIT = 1'b1;

    logic       state_r;
    logic [7:0] pending_r;
    logic [2:0] bout_r;
    logic       valid_r;
    logic       busy_r;
    logic       done_r;
    logic       multihot_r;
    logic [3:0] count_r;

    logic [7:0] pending_clr_s;
    logic [2:0] din_idx_s;
    logic [2:0] next_idx_s;
    logic [3:0] din_cnt_s;

    // Index of the lowest set bit; the loop runs high-to-low so the lowest hit wins.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    // Capture-side and drain-side helpers for the request vector.
    always_comb begin
        pending_clr_s = pending_r & ~(8'd1 << bout_r);
        din_idx_s     = lowest_idx(Din);
        next_idx_s    = lowest_idx(pending_clr_s);
        din_cnt_s     = popcount(Din);
    end

    // Control FSM and registered outputs; abort and reset keep Done low.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= IDLE;
            pending_r  <= 8'd0;
            bout_r     <= 3'd0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            multihot_r <= 1'b0;
            count_r    <= 4'd0;
        end else if (!Enable) begin
            state_r   <= IDLE;
            pending_r <= 8'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (Load) begin
                        count_r    <= din_cnt_s;
                        multihot_r <= (din_cnt_s > 4'd1);
                        if (Din != 8'd0) begin
                            pending_r <= Din;
                            bout_r    <= din_idx_s;
                            valid_r   <= 1'b1;
                            busy_r    <= 1'b1;
                            state_r   <= EMIT;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EMIT: begin
                    done_r <= 1'b0;
                    if (valid_r && Ready) begin
                        pending_r <= pending_clr_s;
                        if (pending_clr_s != 8'd0) begin
                            bout_r <= next_idx_s;
                        end else begin
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pending_r <= 8'd0;
                    valid_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign Bout     = bout_r;
    assign Valid    = valid_r;
    assign Busy     = busy_r;
    assign Done     = done_r;
    assign MultiHot = multihot_r;
    assign Count    = count_r;

endmodule

// File: tb/tb_channel_encoder8_3.sv
// Bench for channel_encoder8_3: scenario tasks checked against a queue-based
// model that lists the set-bit indices of each request in ascending order.
module tb_channel_encoder8_3;

    logic       Clk;
    logic       Rst;
    logic       Enable;
    logic       Load;
    logic [7:0] Din;
    logic       Ready;
    logic [2:0] Bout;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic       MultiHot;
    logic [3:0] Count;

    int tests;
    int fails;

    channel_encoder8_3 dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Load(Load), .Din(Din),
        .Ready(Ready), .Bout(Bout), .Valid(Valid), .Busy(Busy), .Done(Done),
        .MultiHot(MultiHot), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Load one request, drain it with random backpressure, check order and flags.
    task automatic run_request(input logic [7:0] din, input int ready_pct, input logic junk);
        int  exp_q[$];
        int  waits;
        logic rdy;
        for (int i = 0; i < 8; i++) if (din[i]) exp_q.push_back(i);
        Load = 1'b1; Din = din; Ready = 1'b0;
        tick();
        Load = junk;
        Din  = junk ? 8'hFF : 8'($urandom);
        tests++;
        if (Count !== 4'(exp_q.size())) begin
            fails++; $display("FAIL count din=%h: actual=%0d required=%0d", din, Count, exp_q.size());
        end
        tests++;
        if (MultiHot !== (exp_q.size() > 1)) begin
            fails++; $display("FAIL multihot din=%h: actual=%0b required=%0b", din, MultiHot, exp_q.size() > 1);
        end
        if (exp_q.size() == 0) begin
            tests++;
            if (Valid !== 1'b0 || Done !== 1'b1) begin
                fails++; $display("FAIL empty_load: actual valid=%b done=%b required valid=0 done=1", Valid, Done);
            end
            Load = 1'b0;
            tick();
            tests++;
            if (Done !== 1'b0) begin
                fails++; $display("FAIL empty_done_pulse: actual=%b required=0", Done);
            end
            return;
        end
        tests++;
        if (Busy !== 1'b1) begin
            fails++; $display("FAIL busy_on_load: actual=%b required=1", Busy);
        end
        foreach (exp_q[k]) begin
            waits = 0;
            rdy   = 1'b0;
            while (!rdy) begin
                tests++;
                if (Valid !== 1'b1 || Bout !== 3'(exp_q[k])) begin
                    fails++;
                    $display("FAIL stream din=%h: actual valid=%b bout=%0d required valid=1 bout=%0d",
                             din, Valid, Bout, exp_q[k]);
                end
                rdy = (waits >= 20) || ($urandom_range(99) < ready_pct);
                waits++;
                Ready = rdy;
                tick();
            end
        end
        Load = 1'b0; Ready = 1'b0;
        tests++;
        if (Done !== 1'b1 || Valid !== 1'b0 || Busy !== 1'b0) begin
            fails++; $display("FAIL finish din=%h: actual done=%b valid=%b busy=%b required 1 0 0", din, Done, Valid, Busy);
        end
        tick();
        tests++;
        if (Done !== 1'b0 || Valid !== 1'b0) begin
            fails++; $display("FAIL after_done din=%h: actual done=%b valid=%b required 0 0", din, Done, Valid);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Enable = 1'b1; Load = 1'b0; Din = 8'h00; Ready = 1'b0;
        tick();
        tick();
        tests++;
        if ({Bout, Valid, Busy, Done, MultiHot, Count} !== 11'd0) begin
            fails++; $display("FAIL reset: actual=%h required=0", {Bout, Valid, Busy, Done, MultiHot, Count});
        end
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Ready = 1'($urandom);
            Din   = 8'($urandom);
            tick();
            tests++;
            if (Valid !== 1'b0 || Done !== 1'b0) begin
                fails++; $display("FAIL idle: actual valid=%b done=%b required 0 0", Valid, Done);
            end
        end
        Ready = 1'b0;
    endtask

    task automatic test_one_hot_sweep();
        for (int k = 0; k < 8; k++) run_request(8'd1 << k, 100, 1'b0);
    endtask

    task automatic test_multi_hot();
        run_request(8'hA5, 100, 1'b0);
    endtask

    task automatic test_backpressure();
        Load = 1'b1; Din = 8'h81; Ready = 1'b0;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (Valid !== 1'b1 || Bout !== 3'd0) begin
                fails++; $display("FAIL bp_hold: actual valid=%b bout=%0d required 1 0", Valid, Bout);
            end
            tick();
        end
        Ready = 1'b1;
        tests++;
        if (Valid !== 1'b1 || Bout !== 3'd0) begin
            fails++; $display("FAIL bp_first: actual valid=%b bout=%0d required 1 0", Valid, Bout);
        end
        tick();
        tests++;
        if (Valid !== 1'b1 || Bout !== 3'd7 || Done !== 1'b0) begin
            fails++; $display("FAIL bp_second: actual valid=%b bout=%0d done=%b required 1 7 0", Valid, Bout, Done);
        end
        tick();
        Ready = 1'b0;
        tests++;
        if (Done !== 1'b1 || Valid !== 1'b0) begin
            fails++; $display("FAIL bp_done: actual done=%b valid=%b required 1 0", Done, Valid);
        end
        tick();
    endtask

    task automatic test_empty_and_ignored();
        run_request(8'h00, 100, 1'b0);
        run_request(8'h03, 100, 1'b1);
    endtask

    task automatic test_back_to_back();
        Load = 1'b1; Din = 8'h02; Ready = 1'b0;
        tick();
        Load = 1'b0; Ready = 1'b1;
        tick();
        tests++;
        if (Done !== 1'b1) begin
            fails++; $display("FAIL b2b_done: actual=%b required=1", Done);
        end
        Load = 1'b1; Din = 8'h40; Ready = 1'b0;
        tick();
        Load = 1'b0;
        tests++;
        if (Valid !== 1'b1 || Bout !== 3'd6 || Done !== 1'b0 || Count !== 4'd1) begin
            fails++; $display("FAIL b2b_reload: actual valid=%b bout=%0d done=%b count=%0d required 1 6 0 1",
                              Valid, Bout, Done, Count);
        end
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        Load = 1'b1; Din = 8'hF0; Ready = 1'b1;
        tick();
        Load = 1'b0;
        tests++;
        if (Valid !== 1'b1 || Bout !== 3'd4) begin
            fails++; $display("FAIL abort_first: actual valid=%b bout=%0d required 1 4", Valid, Bout);
        end
        tick();
        Enable = 1'b0; Ready = 1'b0;
        tick();
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Bout !== 3'd5 || Count !== 4'd4 || MultiHot !== 1'b1) begin
            fails++; $display("FAIL abort: actual valid=%b busy=%b done=%b bout=%0d count=%0d multi=%b required 0 0 0 5 4 1",
                              Valid, Busy, Done, Bout, Count, MultiHot);
        end
        Load = 1'b1; Din = 8'h11;
        tick();
        tests++;
        if (Valid !== 1'b0 || Done !== 1'b0 || Count !== 4'd4) begin
            fails++; $display("FAIL load_while_disabled: actual valid=%b done=%b count=%0d required 0 0 4", Valid, Done, Count);
        end
        Load = 1'b0; Enable = 1'b1; Ready = 1'b1;
        tick();
        tests++;
        if (Valid !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL post_abort_idle: actual valid=%b done=%b required 0 0", Valid, Done);
        end
        Ready = 1'b0;
        run_request(8'h01, 100, 1'b0);
        Load = 1'b1; Din = 8'h0C;
        tick();
        Load = 1'b0; Rst = 1'b1;
        tick();
        tests++;
        if ({Bout, Valid, Busy, Done, MultiHot, Count} !== 11'd0) begin
            fails++; $display("FAIL rst_mid_emit: actual=%h required=0", {Bout, Valid, Busy, Done, MultiHot, Count});
        end
        Rst = 1'b0; Ready = 1'b1;
        tick();
        tests++;
        if (Valid !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL post_rst: actual valid=%b done=%b required 0 0", Valid, Done);
        end
        Ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_request(8'($urandom), int'($urandom_range(30, 100)), 1'($urandom));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_one_hot_sweep();
        test_multi_hot();
        test_backpressure();
        test_empty_and_ignored();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
